// File: rtl/me_ctrl.sv
// Sequencer for the 4-pel parallel SAD array: streams the template block, then the
// search window, and tracks the minimum candidate SAD and its index.
module me_ctrl #(
  parameter int TB_LEN  = 64,
  parameter int SW_LEN  = 256,
  parameter int SAD_LAT = 66,
  parameter int NCAND   = 64,
  parameter int TB_AW   = 6,
  parameter int SW_AW   = 8,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [TB_AW-1:0] tb_addr,
  output logic [SW_AW-1:0] sw_addr,
  output logic             en_tb,
  output logic             en_sw,
  input  logic [15:0]      sad,
  output logic [15:0]      min_sad,
  output logic [IDX_W-1:0] min_idx
);

  localparam int LAST_BEAT = SAD_LAT + NCAND - 1;
  localparam int BEAT_W    = $clog2(SW_LEN + LAST_BEAT + 1) + 1;

  localparam logic [BEAT_W-1:0] LAT_B  = BEAT_W'(SAD_LAT);
  localparam logic [BEAT_W-1:0] LAST_B = BEAT_W'(LAST_BEAT);
  localparam logic [TB_AW-1:0]  TB_END = TB_AW'(TB_LEN - 1);
  localparam logic [SW_AW-1:0]  SW_END = SW_AW'(SW_LEN - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD_TB   = 2'd1;
  localparam logic [1:0] S_STREAM_SW = 2'd2;
  localparam logic [1:0] S_DRAIN     = 2'd3;

  logic [1:0]        state;
  logic              sw_tail;
  logic [BEAT_W-1:0] beat;
  logic              tb_vld;
  logic              sw_vld;
  logic              in_win;
  logic              last_seen;

  // STREAM_SW keeps one tail cycle after the last address so the final en_sw beat
  // can be closed out (and the search finished) without entering DRAIN.
  assign tb_vld    = (state == S_LOAD_TB);
  assign sw_vld    = (state == S_STREAM_SW) && !sw_tail;
  assign busy      = (state != S_IDLE);
  assign in_win    = busy && (beat >= LAT_B) && (beat <= LAST_B);
  assign last_seen = (beat >= LAST_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sw_tail <= 1'b0;
      beat    <= '0;
      done    <= 1'b0;
      tb_addr <= '0;
      sw_addr <= '0;
      en_tb   <= 1'b0;
      en_sw   <= 1'b0;
      min_sad <= '1;
      min_idx <= '0;
    end else begin
      done  <= 1'b0;
      en_tb <= tb_vld;
      en_sw <= sw_vld;

      // Beat 0 is the first en_sw cycle; the counter idles at zero until then.
      if (en_sw || state == S_DRAIN) beat <= beat + BEAT_W'(1);
      else                           beat <= '0;

      if (in_win && (sad < min_sad)) begin
        min_sad <= sad;
        min_idx <= IDX_W'(beat - LAT_B);
      end

      case (state)
        S_IDLE: begin
          tb_addr <= '0;
          sw_addr <= '0;
          sw_tail <= 1'b0;
          if (start) begin
            state   <= S_LOAD_TB;
            min_sad <= '1;
            min_idx <= '0;
          end
        end
        S_LOAD_TB: begin
          if (tb_addr == TB_END) begin
            tb_addr <= '0;
            sw_addr <= '0;
            state   <= S_STREAM_SW;
          end else begin
            tb_addr <= tb_addr + TB_AW'(1);
          end
        end
        S_STREAM_SW: begin
          if (sw_tail) begin
            sw_tail <= 1'b0;
            sw_addr <= '0;
            if (last_seen) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end else if (sw_addr == SW_END) begin
            sw_tail <= 1'b1;
          end else begin
            sw_addr <= sw_addr + SW_AW'(1);
          end
        end
        S_DRAIN: begin
          if (last_seen) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/me_ctrl.md
# me_ctrl

Sequencer for the 4-pel parallel SAD array in the motion estimation datapath. On a start pulse it streams the template block and then the search window from their on-chip memories into the array, driving `en_tb` and `en_sw`. It samples the array's registered `sad` output once per candidate, tracks the minimum SAD and the winning candidate index, and pulses `done` when the search is complete.

## Interface
Parameters:
- `TB_LEN`, default 64: template words (16x16 block, 4 pels per word).
- `SW_LEN`, default 256: search-window words streamed per search.
- `SAD_LAT`, default 66: beats from the first `en_sw` beat to the first valid candidate SAD on `sad`. This must match the array instance and must be ≥ 1.
- `NCAND`, default 64: candidates evaluated per search.
- `TB_AW` = 6, `SW_AW` = 8, `IDX_W` = 6: address and index widths.

Ports:
- `clk` in 1: single clock for the block.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: start request. Accepted only while `busy` = 0.
- `busy` out 1: search in progress.
- `done` out 1: one-cycle pulse when the search completes.
- `tb_addr` out TB_AW: template memory read address.
- `sw_addr` out SW_AW: search-window memory read address.
- `en_tb` out 1: template load enable to the array.
- `en_sw` out 1: search-window enable to the array.
- `sad` in 16: SAD from the array.
- `min_sad` out 16: best SAD of the last search.
- `min_idx` out IDX_W: candidate index of `min_sad`.

## Operation
- States:
  - IDLE → LOAD_TB → STREAM_SW → DRAIN → IDLE.
  - DRAIN is skipped (STREAM_SW → IDLE) if the last candidate has already been sampled by the end of the stream.
- IDLE:
  - `tb_addr` = `sw_addr` = 0, `en_tb` = `en_sw` = 0, `busy` = 0.
  - When `start` = 1: load `min_sad` = 16'hFFFF and `min_idx` = 0, then go to LOAD_TB.
- LOAD_TB: `tb_addr` counts 0..TB_LEN-1, one per cycle, then the state moves to STREAM_SW.
- STREAM_SW: `sw_addr` counts 0..SW_LEN-1, one per cycle.
- Enable alignment: memories have a 1-cycle read latency, so `en_tb` and `en_sw` are the address-valid flags registered one cycle. Each enable is high exactly TB_LEN (resp. SW_LEN) cycles, aligned with the read data.
- Beat counter:
  - Starts at 0 on the first `en_sw` cycle.
  - Increments every cycle, including in DRAIN.
- Candidate sampling:
  - Candidate k (0..NCAND-1) is sampled at beat SAD_LAT+k.
  - If `sad` < `min_sad` (strict, unsigned 16-bit), set `min_sad` = `sad` and `min_idx` = k.
  - Ties keep the earlier index. All other beats are ignored.
- Search end: after the final sample and the end of the stream, return to IDLE with a `done` pulse.
- `start` while `busy` = 1 is ignored. `start` in the `done` cycle is accepted.

## Timing
- Reset values: `busy` = 0, `done` = 0, `en_tb` = 0, `en_sw` = 0, `tb_addr` = 0, `sw_addr` = 0, `min_sad` = 16'hFFFF, `min_idx` = 0. Assertion takes effect immediately, in any state; the block returns to IDLE.
- Cycle numbering: the edge that samples `start` ends cycle 0.
  - `busy` = 1 from cycle 1.
  - `tb_addr` = i in cycle 1+i.
  - `en_tb` high in cycles 2..TB_LEN+1.
  - `sw_addr` = j in cycle TB_LEN+1+j.
  - `en_sw` high in cycles TB_LEN+2..TB_LEN+SW_LEN+1. Beat 0 is cycle B0 = TB_LEN+2.
- Candidate k is sampled at the edge ending cycle B0+SAD_LAT+k, so its effect is visible on `min_sad` one cycle later.
- Completion:
  - L = max(B0+SAD_LAT+NCAND-1, TB_LEN+SW_LEN+1).
  - `done` = 1 and `busy` = 0 in cycle L+1.
  - `min_sad` and `min_idx` are final in cycle L+1 and hold until the next accepted `start`.
  - With default parameters, `done` is in cycle 322.
- `en_tb` and `en_sw` are never high in the same cycle.

## Test plan
- Defaults; `sad` = 500 on all beats except 100 at the candidate-17 beat (B0+83 = cycle 149) → `done` in cycle 322, `min_sad` = 100, `min_idx` = 17. Also check `en_tb` count = 64 and `en_sw` count = 256.
- `sad` = 200 at candidates 5 and 40, 300 elsewhere → `min_sad` = 200, `min_idx` = 5 (tie keeps earlier). Also check `sad` = 50 at beat SAD_LAT-1 and at beat SAD_LAT+NCAND (out-of-window beats) is ignored.
- `sad` held at 16'hFFFF for the whole search → `min_sad` = 16'hFFFF, `min_idx` = 0, `done` pulses once.
- `start` re-pulsed in cycles 10 and 200 → ignored: single `done` in cycle 322. Then `start` in cycle 322 → a second search with `done` in cycle 644; `min_sad` re-initialised to 16'hFFFF in cycle 323.
- `rst_n` low in cycle 100 (during STREAM_SW) → all outputs at reset values immediately. A new `start` after release behaves like a fresh search.
- Override SAD_LAT = 250, NCAND = 64 → DRAIN used: last sample at B0+313 (cycle 379), `done` in cycle 380.
